// File: rtl/axis_rx_pkg.sv
// ============================================================================
// Module      : axis_rx_pkg
// Description : Shared types and constants for the AXI-Stream frame checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_rx_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    IN_LINE  = 2'd1,
    WAIT_SOL = 2'd2
  } state_t;

  localparam int          TUSER_SOF   = 0;
  localparam int          TUSER_EOF   = 1;
  localparam int          TUSER_SOL   = 2;
  localparam int          TUSER_EOL   = 3;
  localparam logic [15:0] PATTERN_TAG = 16'hA5C3;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] value);
    return value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that holds at all-ones; synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_rx_frame_checker.sv
// ============================================================================
// Module      : axis_rx_frame_checker
// Description : AXI-Stream image sink checking frame/line geometry, tuser/tlast
//               sequencing and an optional payload pattern.
//               Macro AXIS_RX_THROTTLE_EN: LFSR-gated tready for backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_rx_frame_checker
  import axis_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aclk_reset_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  cfg_enable,
  input  logic                  cfg_pattern_en,
  input  logic [CNT_WIDTH-1:0]  cfg_line_beats,
  input  logic [CNT_WIDTH-1:0]  cfg_lines,
  input  logic                  clear,
  output logic [31:0]           frame_cnt,
  output logic [CNT_WIDTH-1:0]  geom_err_cnt,
  output logic [CNT_WIDTH-1:0]  proto_err_cnt,
  output logic [CNT_WIDTH-1:0]  data_err_cnt,
  output logic                  frame_done,
  output logic                  err_sticky
);

  state_t      state, state_nxt;
  logic [15:0] beat_idx, beat_nxt;
  logic [15:0] line_idx, line_nxt;
  logic [15:0] cur_beat, cur_line;
  logic        ready_q;
  logic        xfer;
  logic        in_frame, new_frame, new_line;
  logic        proto_err, geom_err, data_err, frame_end;
  logic        sof, eof, sol, eol;
  logic [DATA_WIDTH-1:0] expected;

  assign sof  = s_axis_tuser[TUSER_SOF];
  assign eof  = s_axis_tuser[TUSER_EOF];
  assign sol  = s_axis_tuser[TUSER_SOL];
  assign eol  = s_axis_tuser[TUSER_EOL];
  assign xfer = s_axis_tvalid && s_axis_tready && cfg_enable;

`ifdef AXIS_RX_THROTTLE_EN
  logic [15:0] lfsr;

  always_ff @(posedge aclk) begin
    if (!aclk_reset_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  assign s_axis_tready = ready_q && (!cfg_enable || (lfsr[1:0] != 2'b00));
`else
  assign s_axis_tready = ready_q;
`endif

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_idx;
    line_nxt  = line_idx;
    cur_beat  = beat_idx;
    cur_line  = line_idx;
    in_frame  = 1'b0;
    new_frame = 1'b0;
    new_line  = 1'b0;
    proto_err = 1'b0;
    geom_err  = 1'b0;
    data_err  = 1'b0;
    frame_end = 1'b0;
    expected  = '0;

    if (xfer) begin
      case (state)
        WAIT_SOF: begin
          if (sof) begin
            in_frame  = 1'b1;
            new_frame = 1'b1;
          end else begin
            proto_err = 1'b1;
          end
        end
        IN_LINE: begin
          in_frame = 1'b1;
          if (sof) begin
            proto_err = 1'b1;
            new_frame = 1'b1;
          end else if (sol) begin
            // Unterminated line: resync as a fresh line after it.
            proto_err = 1'b1;
            new_line  = 1'b1;
            cur_line  = line_idx + 16'd1;
          end
        end
        WAIT_SOL: begin
          in_frame = 1'b1;
          if (sof) begin
            proto_err = 1'b1;
            new_frame = 1'b1;
          end else begin
            new_line = 1'b1;
            if (!sol) proto_err = 1'b1;
          end
        end
        default: state_nxt = WAIT_SOF;
      endcase
    end

    if (new_frame) begin
      cur_line = 16'd0;
      cur_beat = 16'd0;
    end else if (new_line) begin
      cur_beat = 16'd0;
    end

    if (in_frame) begin
      state_nxt = IN_LINE;
      line_nxt  = cur_line;
      beat_nxt  = (cur_beat == 16'hFFFF) ? cur_beat : cur_beat + 16'd1;
      if (s_axis_tlast != eol) proto_err = 1'b1;
      // A saturated beat_idx yields 0x10000 here, so overrun always mismatches.
      if (s_axis_tlast) begin
        if (({1'b0, cur_beat} + 17'd1) != {1'b0, cfg_line_beats}) geom_err = 1'b1;
        if (eof) begin
          if (({1'b0, cur_line} + 17'd1) != {1'b0, cfg_lines}) geom_err = 1'b1;
          frame_end = 1'b1;
          state_nxt = WAIT_SOF;
        end else begin
          state_nxt = WAIT_SOL;
          line_nxt  = cur_line + 16'd1;
        end
      end else if (eof) begin
        proto_err = 1'b1;
        frame_end = 1'b1;
        state_nxt = WAIT_SOF;
      end
      expected = {frame_cnt[15:0], cur_line, cur_beat, PATTERN_TAG};
      data_err = cfg_pattern_en && (s_axis_tdata != expected);
    end

    if (!cfg_enable) state_nxt = WAIT_SOF;
    if (state_nxt == WAIT_SOF) begin
      beat_nxt = 16'd0;
      line_nxt = 16'd0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aclk_reset_n) begin
      state    <= WAIT_SOF;
      beat_idx <= 16'd0;
      line_idx <= 16'd0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_idx <= beat_nxt;
      line_idx <= line_nxt;
      ready_q  <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aclk_reset_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aclk_reset_n || clear) begin
      frame_cnt  <= 32'd0;
      err_sticky <= 1'b0;
    end else begin
      if (frame_end) frame_cnt <= frame_cnt + 32'd1;
      if (proto_err || geom_err || data_err) err_sticky <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_geom_cnt (
    .clk   (aclk),
    .rst_n (aclk_reset_n),
    .inc   (geom_err),
    .clr   (clear),
    .count (geom_err_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_proto_cnt (
    .clk   (aclk),
    .rst_n (aclk_reset_n),
    .inc   (proto_err),
    .clr   (clear),
    .count (proto_err_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_data_cnt (
    .clk   (aclk),
    .rst_n (aclk_reset_n),
    .inc   (data_err),
    .clr   (clear),
    .count (data_err_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_axis_rx_frame_checker.sv
// ============================================================================
// Module      : tb_axis_rx_frame_checker
// Description : Directed self-checking bench for axis_rx_frame_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_rx_frame_checker;

  logic        aclk = 1'b0;
  logic        aclk_reset_n = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic [3:0]  s_axis_tuser = '0;
  logic        cfg_enable = 1'b1;
  logic        cfg_pattern_en = 1'b1;
  logic [15:0] cfg_line_beats = 16'd4;
  logic [15:0] cfg_lines = 16'd3;
  logic        clear = 1'b0;
  logic [31:0] frame_cnt;
  logic [15:0] geom_err_cnt, proto_err_cnt, data_err_cnt;
  logic        frame_done, err_sticky;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  axis_rx_frame_checker dut (
    .aclk           (aclk),
    .aclk_reset_n   (aclk_reset_n),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .cfg_enable     (cfg_enable),
    .cfg_pattern_en (cfg_pattern_en),
    .cfg_line_beats (cfg_line_beats),
    .cfg_lines      (cfg_lines),
    .clear          (clear),
    .frame_cnt      (frame_cnt),
    .geom_err_cnt   (geom_err_cnt),
    .proto_err_cnt  (proto_err_cnt),
    .data_err_cnt   (data_err_cnt),
    .frame_done     (frame_done),
    .err_sticky     (err_sticky)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) if (frame_done === 1'b1) done_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // Drive one beat at the falling edge and hold it until it transfers.
  task automatic send_beat(input logic [63:0] d, input logic last, input logic [3:0] u,
                           input logic clr);
    int guard;
    guard = 0;
    @(negedge aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tuser  = u;
    clear         = clr;
    while (!s_axis_tready && guard < 64) begin
      @(negedge aclk);
      guard++;
    end
    if (guard >= 64) begin
      total++;
      bad++;
      $display("FAIL tready_timeout: got=0 exp=1");
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    clear         = 1'b0;
  endtask

  task automatic send_line(input logic [15:0] f, input logic [15:0] l, input int nbeats,
                           input bit first, input bit last_line, input int flip);
    logic [3:0]  u;
    logic [63:0] d;
    for (int b = 0; b < nbeats; b++) begin
      u = 4'b0000;
      d = {f, l, 16'(b), 16'hA5C3};
      if (b == flip) d[20] = ~d[20];
      if (b == 0) begin
        u[2] = 1'b1;
        if (first) u[0] = 1'b1;
      end
      if (b == nbeats - 1) begin
        u[3] = 1'b1;
        if (last_line) u[1] = 1'b1;
      end
      send_beat(d, (b == nbeats - 1), u, 1'b0);
    end
  endtask

  // 3 lines of 4 beats; long_line gets 5 beats, flip_beat corrupts line 0.
  task automatic send_frame(input logic [15:0] f, input int long_line, input int flip_beat);
    for (int l = 0; l < 3; l++) begin
      send_line(f, 16'(l), (l == long_line) ? 5 : 4, (l == 0), (l == 2),
                (l == 0) ? flip_beat : -1);
    end
  endtask

  task automatic pulse_clear();
    @(negedge aclk);
    clear = 1'b1;
    @(negedge aclk);
    clear = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    aclk_reset_n  = 1'b0;
    s_axis_tvalid = 1'b0;
    idle(2);
    aclk_reset_n = 1'b1;
  endtask

  function automatic logic ready_after_reset();
    logic [15:0] lf;
    lf = 16'hACE1;
`ifdef AXIS_RX_THROTTLE_EN
    lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
    return (lf[1:0] != 2'b00);
`else
    return (lf != 16'd0);
`endif
  endfunction

  initial begin
    int base;
    int rdy;

    // Reset state
    idle(2);
    check_eq("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    check_eq("rst_frame_cnt", frame_cnt, 32'd0);
    check_eq("rst_geom", {16'd0, geom_err_cnt}, 32'd0);
    check_eq("rst_proto", {16'd0, proto_err_cnt}, 32'd0);
    check_eq("rst_data", {16'd0, data_err_cnt}, 32'd0);
    check_eq("rst_done", {31'd0, frame_done}, 32'd0);
    check_eq("rst_sticky", {31'd0, err_sticky}, 32'd0);
    aclk_reset_n = 1'b1;
    idle(1);
    check_eq("release_tready", {31'd0, s_axis_tready}, {31'd0, ready_after_reset()});

    // Two clean frames
    base = done_seen;
    send_frame(16'd0, -1, -1);
    send_frame(16'd1, -1, -1);
    idle(3);
    check_eq("clean_frame_cnt", frame_cnt, 32'd2);
    check_eq("clean_geom", {16'd0, geom_err_cnt}, 32'd0);
    check_eq("clean_proto", {16'd0, proto_err_cnt}, 32'd0);
    check_eq("clean_data", {16'd0, data_err_cnt}, 32'd0);
    check_eq("clean_done_pulses", done_seen - base, 32'd2);
    check_eq("clean_sticky", {31'd0, err_sticky}, 32'd0);

    // Line 1 carries 5 beats
    pulse_clear();
    send_frame(16'd0, 1, -1);
    idle(2);
    check_eq("long_geom", {16'd0, geom_err_cnt}, 32'd1);
    check_eq("long_sticky", {31'd0, err_sticky}, 32'd1);
    check_eq("long_frame_cnt", frame_cnt, 32'd1);
    check_eq("long_proto", {16'd0, proto_err_cnt}, 32'd0);

    // Beat without SOF after reset is dropped
    apply_reset();
    send_beat({16'd0, 16'd0, 16'd0, 16'hA5C3}, 1'b0, 4'b0100, 1'b0);
    idle(1);
    check_eq("nosof_proto", {16'd0, proto_err_cnt}, 32'd1);
    send_frame(16'd0, -1, -1);
    idle(2);
    check_eq("nosof_frame_cnt", frame_cnt, 32'd1);
    check_eq("nosof_geom", {16'd0, geom_err_cnt}, 32'd0);
    check_eq("nosof_proto_hold", {16'd0, proto_err_cnt}, 32'd1);

    // Payload bit 20 flipped on beat 2 of line 0
    pulse_clear();
    send_frame(16'd0, -1, 2);
    idle(2);
    check_eq("flip_data", {16'd0, data_err_cnt}, 32'd1);
    check_eq("flip_geom", {16'd0, geom_err_cnt}, 32'd0);
    pulse_clear();
    cfg_pattern_en = 1'b0;
    send_frame(16'd0, -1, 2);
    idle(2);
    check_eq("flip_nopat_data", {16'd0, data_err_cnt}, 32'd0);
    check_eq("flip_nopat_sticky", {31'd0, err_sticky}, 32'd0);
    check_eq("flip_nopat_frames", frame_cnt, 32'd1);

    // Geometry error saturation with single-beat frames
    pulse_clear();
    cfg_line_beats = 16'd2;
    cfg_lines      = 16'd1;
    for (int i = 0; i < 70000; i++) begin
      send_beat(64'd0, 1'b1, 4'b1111, 1'b0);
    end
    idle(2);
    check_eq("sat_geom", {16'd0, geom_err_cnt}, 32'h0000FFFF);
    check_eq("sat_frame_cnt", frame_cnt, 32'd70000);
    check_eq("sat_proto", {16'd0, proto_err_cnt}, 32'd0);
    send_beat(64'd0, 1'b1, 4'b1111, 1'b1);
    idle(1);
    check_eq("clr_geom", {16'd0, geom_err_cnt}, 32'd0);
    check_eq("clr_frame_cnt", frame_cnt, 32'd0);
    check_eq("clr_sticky", {31'd0, err_sticky}, 32'd0);

    // Reset in the middle of a line
    cfg_line_beats = 16'd4;
    cfg_lines      = 16'd3;
    cfg_pattern_en = 1'b1;
    send_beat({16'd0, 16'd0, 16'd0, 16'hA5C3}, 1'b0, 4'b0101, 1'b0);
    send_beat({16'd0, 16'd0, 16'd1, 16'hA5C3}, 1'b0, 4'b0000, 1'b0);
    @(negedge aclk);
    aclk_reset_n = 1'b0;
    idle(1);
    check_eq("midrst_tready", {31'd0, s_axis_tready}, 32'd0);
    aclk_reset_n = 1'b1;
    idle(1);
    check_eq("midrst_release_tready", {31'd0, s_axis_tready}, {31'd0, ready_after_reset()});
    send_frame(16'd0, -1, -1);
    idle(2);
    check_eq("midrst_frame_cnt", frame_cnt, 32'd1);
    check_eq("midrst_proto", {16'd0, proto_err_cnt}, 32'd0);
    check_eq("midrst_geom", {16'd0, geom_err_cnt}, 32'd0);
    check_eq("midrst_data", {16'd0, data_err_cnt}, 32'd0);
    check_eq("midrst_sticky", {31'd0, err_sticky}, 32'd0);

    // Disabled checker drops beats uncounted
    cfg_enable = 1'b0;
    idle(1);
    check_eq("dis_tready", {31'd0, s_axis_tready}, 32'd1);
    send_beat(64'd0, 1'b0, 4'b0100, 1'b0);
    idle(1);
    check_eq("dis_proto", {16'd0, proto_err_cnt}, 32'd0);
    check_eq("dis_frame_cnt", frame_cnt, 32'd1);
    cfg_enable = 1'b1;

`ifdef AXIS_RX_THROTTLE_EN
    rdy = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge aclk);
      if (s_axis_tready) rdy++;
    end
    check_eq("throttle_duty", {31'd0, (rdy >= 2868 && rdy <= 3276)}, 32'd1);
`else
    rdy = 0;
    idle(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
